// File: rtl/divide_reconstruct_if.sv
// Operand/result bundle between a divider self-check client and divide_reconstruct.
// The master drives operands and the slave (the reconstructor) returns results.
interface divide_reconstruct_if;
  logic        valid_in;
  logic [31:0] quotient;
  logic [15:0] divisor;
  logic [15:0] remainder;
  logic        busy;
  logic [31:0] dividend;
  logic        overflow;
  logic        rem_err;
  logic        valid_out;

  modport master (
    output valid_in, quotient, divisor, remainder,
    input  busy, dividend, overflow, rem_err, valid_out
  );

  modport slave (
    input  valid_in, quotient, divisor, remainder,
    output busy, dividend, overflow, rem_err, valid_out
  );
endinterface

// File: rtl/divide_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder with a fixed 16-iteration
// shift-add multiplier, and flags remainders that are not below the divisor.
module divide_reconstruct (
  input  logic                  clk,
  input  logic                  reset,
  divide_reconstruct_if.slave   bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [48:0] acc, next_acc;
  logic [47:0] mcand;
  logic [15:0] mplier;
  logic [3:0]  cnt;
  logic        rem_err_r;
  logic        accept, last, busy;

  logic [31:0] dividend_q;
  logic        overflow_q, rem_err_q, valid_out_q;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.valid_in) state_nxt = RUN;
      RUN:     if (cnt == 4'd15) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded controls
  always_comb begin
    busy   = 1'b0;
    accept = 1'b0;
    last   = 1'b0;
    case (state)
      IDLE: accept = bus.valid_in;
      RUN: begin
        busy = 1'b1;
        last = (cnt == 4'd15);
      end
      default: ;
    endcase
  end

  // 49-bit accumulator never wraps: max sum is (2^32-1)(2^16-1) + 2^16-1
  always_comb begin
    next_acc = acc;
    if (mplier[0]) next_acc = acc + {1'b0, mcand};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      rem_err_r   <= 1'b0;
      dividend_q  <= '0;
      overflow_q  <= 1'b0;
      rem_err_q   <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      if (accept) begin
        acc       <= {33'b0, bus.remainder};
        mcand     <= {16'b0, bus.quotient};
        mplier    <= bus.divisor;
        rem_err_r <= (bus.remainder >= bus.divisor);
        cnt       <= '0;
      end else if (busy) begin
        acc    <= next_acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 4'd1;
        if (last) begin
          dividend_q  <= next_acc[31:0];
          overflow_q  <= |next_acc[48:32];
          rem_err_q   <= rem_err_r;
          valid_out_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.dividend  = dividend_q;
  assign bus.overflow  = overflow_q;
  assign bus.rem_err   = rem_err_q;
  assign bus.valid_out = valid_out_q;
endmodule
